// File: rtl/alu_cmd_issuer.sv
// Registered command/response front-end for a combinational 32-bit ALU; result captured ALU_LAT cycles after issue.
// Optional `ILLEGAL_OP_CHECK_EN`: opcodes 7..15 are answered at once with rsp_err=1 instead of being issued.
module alu_cmd_issuer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_opcode,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  input  logic [SHAMT_W-1:0] cmd_shamt,
  output logic [3:0]         alu_opcode,
  output logic [WIDTH-1:0]   alu_input1,
  output logic [WIDTH-1:0]   alu_input2,
  output logic [SHAMT_W-1:0] alu_shift,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_carry,
  input  logic               alu_zero,
  input  logic               alu_ovf,
  input  logic               alu_sign,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_carry,
  output logic               rsp_zero,
  output logic               rsp_ovf,
  output logic               rsp_sign,
  output logic               rsp_err,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t             state_q;
  logic [3:0]         cnt_q;
  logic [3:0]         alu_opcode_q;
  logic [WIDTH-1:0]   alu_input1_q;
  logic [WIDTH-1:0]   alu_input2_q;
  logic [SHAMT_W-1:0] alu_shift_q;
  logic               rsp_valid_q;
  logic [WIDTH-1:0]   rsp_result_q;
  logic               rsp_carry_q;
  logic               rsp_zero_q;
  logic               rsp_ovf_q;
  logic               rsp_sign_q;
  logic               rsp_err_q;
  logic [CNT_W-1:0]   op_count_q;

  logic is_arith;
  logic illegal_op;

  // Carry and overflow only mean something for the op held in the drive register when it is ADD/SUB.
  assign is_arith = (alu_opcode_q == OP_ADD) || (alu_opcode_q == OP_SUB);

`ifdef ILLEGAL_OP_CHECK_EN
  assign illegal_op = (cmd_opcode > 4'd6);
`else
  assign illegal_op = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      alu_opcode_q <= '0;
      alu_input1_q <= '0;
      alu_input2_q <= '0;
      alu_shift_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_sign_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      op_count_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            if (illegal_op) begin
              rsp_result_q <= '0;
              rsp_carry_q  <= 1'b0;
              rsp_zero_q   <= 1'b0;
              rsp_ovf_q    <= 1'b0;
              rsp_sign_q   <= 1'b0;
              rsp_err_q    <= 1'b1;
              rsp_valid_q  <= 1'b1;
              state_q      <= S_RESP;
            end else begin
              alu_opcode_q <= cmd_opcode;
              alu_input1_q <= cmd_a;
              alu_input2_q <= cmd_b;
              alu_shift_q  <= cmd_shamt;
              cnt_q        <= LAT_M1;
              state_q      <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            rsp_result_q <= alu_result;
            rsp_carry_q  <= alu_carry & is_arith;
            rsp_zero_q   <= alu_zero;
            rsp_ovf_q    <= alu_ovf & is_arith;
            rsp_sign_q   <= alu_sign;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + CNT_W'(1);
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign alu_opcode = alu_opcode_q;
  assign alu_input1 = alu_input1_q;
  assign alu_input2 = alu_input2_q;
  assign alu_shift  = alu_shift_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign rsp_sign   = rsp_sign_q;
  assign rsp_err    = rsp_err_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: two instances (ALU_LAT=1 and ALU_LAT=3) each driven by a behavioural ALU stub.
`timescale 1ns/1ps
module tb_alu_cmd_issuer;
  localparam int W  = 32;
  localparam int SW = 5;
  localparam int CW = 16;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         v;
    logic         s;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [3:0]    cmd_opcode, alu_opcode;
  logic [W-1:0]  cmd_a, cmd_b, alu_input1, alu_input2, alu_result, rsp_result;
  logic [SW-1:0] cmd_shamt, alu_shift;
  logic          alu_carry, alu_zero, alu_ovf, alu_sign;
  logic          rsp_carry, rsp_zero, rsp_ovf, rsp_sign, rsp_err, busy;
  logic [CW-1:0] op_count;

  logic          rst3_n, l3_cmd_valid, l3_cmd_ready, l3_rsp_valid, l3_rsp_ready;
  logic [3:0]    l3_cmd_opcode, l3_alu_opcode;
  logic [W-1:0]  l3_cmd_a, l3_cmd_b, l3_alu_input1, l3_alu_input2, l3_alu_result, l3_rsp_result;
  logic [SW-1:0] l3_cmd_shamt, l3_alu_shift;
  logic          l3_alu_carry, l3_alu_zero, l3_alu_ovf, l3_alu_sign;
  logic          l3_rsp_carry, l3_rsp_zero, l3_rsp_ovf, l3_rsp_sign, l3_rsp_err, l3_busy;
  logic [CW-1:0] l3_op_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_count = 0;

  // Behavioural ALU; carry/ovf deliberately driven high for non-arithmetic ops.
  function automatic res_t alu_ref(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [SW-1:0] sh);
    res_t o;
    logic [W:0] t;
    o = '0;
    o.c = 1'b1;
    o.v = 1'b1;
    case (op)
      4'd0: begin t = {1'b0, a} + {1'b0, b}; o.r = t[W-1:0]; o.c = t[W];
                  o.v = (a[W-1] == b[W-1]) && (o.r[W-1] != a[W-1]); end
      4'd1: begin t = {1'b0, a} - {1'b0, b}; o.r = t[W-1:0]; o.c = t[W];
                  o.v = (a[W-1] != b[W-1]) && (o.r[W-1] != a[W-1]); end
      4'd2: o.r = a & b;
      4'd3: o.r = a | b;
      4'd4: o.r = a << sh;
      4'd5: o.r = a * b;
      4'd6: o.r = $signed(a) >>> sh;
      default: o.r = a ^ b;
    endcase
    o.z = (o.r == '0);
    o.s = o.r[W-1];
    return o;
  endfunction

  function automatic logic op_illegal(input logic [3:0] op);
`ifdef ILLEGAL_OP_CHECK_EN
    return op > 4'd6;
`else
    return 1'b0;
`endif
  endfunction

  function automatic res_t expect_rsp(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [SW-1:0] sh);
    res_t o;
    if (op_illegal(op)) return '0;
    o = alu_ref(op, a, b, sh);
    if (op > 4'd1) begin o.c = 1'b0; o.v = 1'b0; end
    return o;
  endfunction

  assign {alu_result, alu_carry, alu_zero, alu_ovf, alu_sign} = alu_ref(alu_opcode, alu_input1, alu_input2, alu_shift);
  assign {l3_alu_result, l3_alu_carry, l3_alu_zero, l3_alu_ovf, l3_alu_sign} =
         alu_ref(l3_alu_opcode, l3_alu_input1, l3_alu_input2, l3_alu_shift);

  alu_cmd_issuer #(.WIDTH(W), .SHAMT_W(SW), .ALU_LAT(1), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shamt(cmd_shamt), .alu_opcode(alu_opcode), .alu_input1(alu_input1),
    .alu_input2(alu_input2), .alu_shift(alu_shift), .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_sign(alu_sign), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_sign(rsp_sign),
    .rsp_err(rsp_err), .busy(busy), .op_count(op_count));

  alu_cmd_issuer #(.WIDTH(W), .SHAMT_W(SW), .ALU_LAT(3), .CNT_W(CW)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .cmd_valid(l3_cmd_valid), .cmd_ready(l3_cmd_ready), .cmd_opcode(l3_cmd_opcode),
    .cmd_a(l3_cmd_a), .cmd_b(l3_cmd_b), .cmd_shamt(l3_cmd_shamt), .alu_opcode(l3_alu_opcode),
    .alu_input1(l3_alu_input1), .alu_input2(l3_alu_input2), .alu_shift(l3_alu_shift), .alu_result(l3_alu_result),
    .alu_carry(l3_alu_carry), .alu_zero(l3_alu_zero), .alu_ovf(l3_alu_ovf), .alu_sign(l3_alu_sign),
    .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_ready), .rsp_result(l3_rsp_result), .rsp_carry(l3_rsp_carry),
    .rsp_zero(l3_rsp_zero), .rsp_ovf(l3_rsp_ovf), .rsp_sign(l3_rsp_sign), .rsp_err(l3_rsp_err),
    .busy(l3_busy), .op_count(l3_op_count));

  // Drives one command into u_dut and completes its response after `hold` stalled cycles.
  // lat counts rising edges from the accepting edge (inclusive) to the first cycle rsp_valid is seen.
  // While the op is in flight, junk commands with cmd_valid high are presented and must be ignored.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [SW-1:0] sh, input int hold,
                        output int lat, output res_t got, output logic err, output bit to);
    int k;
    to = 1'b0; lat = 0; got = '0; err = 1'b0;
    @(negedge clk);
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    if (!cmd_ready) begin to = 1'b1; return; end
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_shamt = sh; rsp_ready = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      cmd_opcode = 4'($urandom); cmd_a = $urandom; cmd_b = $urandom; cmd_shamt = SW'($urandom);
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin cmd_valid = 1'b0; to = 1'b1; return; end
    got = {rsp_result, rsp_carry, rsp_zero, rsp_ovf, rsp_sign};
    err = rsp_err;
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    exp_count++;
  endtask

  task automatic test_reset();
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_tests++; if (op_count !== '0) begin n_fail++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
    n_tests++; if ({alu_opcode, alu_input1, alu_input2, alu_shift} !== '0)
      begin n_fail++; $display("FAIL reset_alu_drive got=%h exp=0", {alu_opcode, alu_input1, alu_input2, alu_shift}); end
    n_tests++; if ({rsp_result, rsp_carry, rsp_zero, rsp_ovf, rsp_sign, rsp_err} !== '0)
      begin n_fail++; $display("FAIL reset_rsp_regs got=%h exp=0", {rsp_result, rsp_carry, rsp_zero, rsp_ovf, rsp_sign, rsp_err}); end
  endtask

  task automatic test_add_carry();
    int lat; res_t got; logic err; bit to;
    run_op(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 0, lat, got, err, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL add_timeout got=%b exp=0", to); end
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL add_latency got=%0d exp=2", lat); end
    n_tests++; if (got !== {32'h0, 1'b1, 1'b1, 1'b0, 1'b0})
      begin n_fail++; $display("FAIL add_carry_rsp got=%h exp=%h", got, {32'h0, 4'b1100}); end
    n_tests++; if ({alu_input1, alu_input2} !== {32'hFFFF_FFFF, 32'h1})
      begin n_fail++; $display("FAIL add_alu_drive got=%h exp=%h", {alu_input1, alu_input2}, {32'hFFFF_FFFF, 32'h1}); end
    n_tests++; if (op_count !== CW'(exp_count)) begin n_fail++; $display("FAIL add_op_count got=%0d exp=%0d", op_count, exp_count); end
  endtask

  task automatic test_flags();
    int lat; res_t got; logic err; bit to;
    run_op(4'd1, 32'd5, 32'd7, 5'd0, 1, lat, got, err, to);
    n_tests++; if (to !== 1'b0 || got.r !== 32'hFFFF_FFFE || got.s !== 1'b1 || got.z !== 1'b0)
      begin n_fail++; $display("FAIL sub_neg got=%h s=%b z=%b exp=fffffffe s=1 z=0", got.r, got.s, got.z); end
    run_op(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 0, lat, got, err, to);
    n_tests++; if (to !== 1'b0 || got.r !== 32'h8000_0000 || got.v !== 1'b1 || got.s !== 1'b1 || got.c !== 1'b0)
      begin n_fail++; $display("FAIL add_ovf got=%h v=%b s=%b c=%b exp=80000000 v=1 s=1 c=0", got.r, got.v, got.s, got.c); end
  endtask

  task automatic test_sra_mask();
    int lat; res_t got; logic err; bit to;
    run_op(4'd6, 32'h8000_0000, 32'h0, 5'd4, 0, lat, got, err, to);
    n_tests++; if (to !== 1'b0 || got !== {32'hF800_0000, 1'b0, 1'b0, 1'b0, 1'b1})
      begin n_fail++; $display("FAIL sra_mask got=%h exp=%h", got, {32'hF800_0000, 4'b0001}); end
  endtask

  task automatic test_backpressure();
    int k;
    res_t e;
    e = expect_rsp(4'd3, 32'h1234_0000, 32'h0000_5678, 5'd0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = 4'd3; cmd_a = 32'h1234_0000; cmd_b = 32'h0000_5678; cmd_shamt = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
    n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_timeout got=%b exp=1", rsp_valid); end
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if ({rsp_result, rsp_carry, rsp_zero, rsp_ovf, rsp_sign} !== e || cmd_ready !== 1'b0 || busy !== 1'b1 ||
          rsp_valid !== 1'b1 || op_count !== CW'(exp_count)) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d got=%h rdy=%b busy=%b vld=%b cnt=%0d exp=%h rdy=0 busy=1 vld=1 cnt=%0d",
                 i, {rsp_result, rsp_carry, rsp_zero, rsp_ovf, rsp_sign}, cmd_ready, busy, rsp_valid, op_count, e, exp_count);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_count++;
    n_tests++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || op_count !== CW'(exp_count))
      begin n_fail++; $display("FAIL bp_release rdy=%b vld=%b cnt=%0d exp rdy=1 vld=0 cnt=%0d", cmd_ready, rsp_valid, op_count, exp_count); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = 4'd0; cmd_a = 32'd1; cmd_b = 32'd2; cmd_shamt = '0; rsp_ready = 1'b1;
    repeat (8) @(negedge clk);
    n_tests++; if (op_count !== CW'(exp_count + 2)) begin n_fail++; $display("FAIL b2b_8cyc got=%0d exp=%0d", op_count, exp_count + 2); end
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    exp_count += 3;
    n_tests++; if (op_count !== CW'(exp_count) || cmd_ready !== 1'b1)
      begin n_fail++; $display("FAIL b2b_9cyc got=%0d rdy=%b exp=%0d rdy=1", op_count, cmd_ready, exp_count); end
  endtask

  task automatic test_illegal();
    int lat; res_t got; logic err; bit to;
    run_op(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 0, lat, got, err, to);
    run_op(4'd9, 32'hAAAA_0001, 32'h5555_0003, 5'd3, 0, lat, got, err, to);
`ifdef ILLEGAL_OP_CHECK_EN
    n_tests++; if (to !== 1'b0 || lat !== 1 || err !== 1'b1 || got !== '0 || alu_opcode !== 4'd2)
      begin n_fail++; $display("FAIL illegal_op lat=%0d err=%b rsp=%h aop=%0d exp lat=1 err=1 rsp=0 aop=2", lat, err, got, alu_opcode); end
`else
    n_tests++; if (to !== 1'b0 || lat !== 2 || err !== 1'b0 || alu_opcode !== 4'd9 || alu_input1 !== 32'hAAAA_0001)
      begin n_fail++; $display("FAIL op9_issue lat=%0d err=%b aop=%0d a=%h exp lat=2 err=0 aop=9 a=aaaa0001", lat, err, alu_opcode, alu_input1); end
`endif
    n_tests++; if (op_count !== CW'(exp_count)) begin n_fail++; $display("FAIL illegal_count got=%0d exp=%0d", op_count, exp_count); end
  endtask

  task automatic test_random();
    int lat; res_t got; logic err; bit to;
    logic [3:0] op; logic [W-1:0] a, b; logic [SW-1:0] sh; res_t e;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 9));
      a  = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
      b  = (i % 7 == 0) ? a : $urandom;
      sh = SW'($urandom);
      e  = expect_rsp(op, a, b, sh);
      run_op(op, a, b, sh, $urandom_range(0, 2), lat, got, err, to);
      n_tests++;
      if (to !== 1'b0 || got !== e || err !== op_illegal(op) || lat !== (op_illegal(op) ? 1 : 2) ||
          op_count !== CW'(exp_count) || (!op_illegal(op) && {alu_opcode, alu_input1, alu_input2, alu_shift} !== {op, a, b, sh})) begin
        n_fail++;
        $display("FAIL rand_%0d op=%0d got=%h err=%b lat=%0d cnt=%0d exp=%h err=%b cnt=%0d", i, op, got, err, lat,
                 op_count, e, op_illegal(op), exp_count);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int k;
    @(negedge clk);
    l3_cmd_valid = 1'b1; l3_cmd_opcode = 4'd0; l3_cmd_a = 32'd3; l3_cmd_b = 32'd4; l3_cmd_shamt = '0;
    @(negedge clk);
    l3_cmd_valid = 1'b0;
    @(posedge clk);
    #2;
    n_tests++; if (l3_busy !== 1'b1 || l3_rsp_valid !== 1'b0)
      begin n_fail++; $display("FAIL mid_before busy=%b vld=%b exp busy=1 vld=0", l3_busy, l3_rsp_valid); end
    rst3_n = 1'b0;
    #1;
    n_tests++;
    if (l3_rsp_valid !== 1'b0 || l3_busy !== 1'b0 || l3_op_count !== '0 || l3_alu_input1 !== '0 || l3_rsp_result !== '0) begin
      n_fail++;
      $display("FAIL mid_reset vld=%b busy=%b cnt=%0d a=%h res=%h exp all 0", l3_rsp_valid, l3_busy, l3_op_count, l3_alu_input1, l3_rsp_result);
    end
    repeat (3) @(negedge clk);
    rst3_n = 1'b1;
    @(negedge clk);
    n_tests++; if (l3_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp got=%b exp=0", l3_rsp_valid); end
    l3_cmd_valid = 1'b1; l3_cmd_opcode = 4'd1; l3_cmd_a = 32'd10; l3_cmd_b = 32'd3;
    @(negedge clk);
    l3_cmd_valid = 1'b0;
    k = 1;
    while (!l3_rsp_valid && k < 50) begin @(negedge clk); k++; end
    n_tests++; if (k !== 4 || l3_rsp_result !== 32'd7 || l3_rsp_err !== 1'b0)
      begin n_fail++; $display("FAIL mid_fresh lat=%0d res=%h err=%b exp lat=4 res=7 err=0", k, l3_rsp_result, l3_rsp_err); end
    l3_rsp_ready = 1'b1;
    @(negedge clk);
    l3_rsp_ready = 1'b0;
    n_tests++; if (l3_op_count !== CW'(1) || l3_cmd_ready !== 1'b1)
      begin n_fail++; $display("FAIL mid_count got=%0d rdy=%b exp=1 rdy=1", l3_op_count, l3_cmd_ready); end
  endtask

  initial begin
    rst_n = 1'b0; rst3_n = 1'b0;
    cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0; cmd_shamt = '0; rsp_ready = 1'b0;
    l3_cmd_valid = 1'b0; l3_cmd_opcode = '0; l3_cmd_a = '0; l3_cmd_b = '0; l3_cmd_shamt = '0; l3_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1; rst3_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_add_carry();
    test_flags();
    test_sra_mask();
    test_backpressure();
    test_back_to_back();
    test_illegal();
    test_random();
    test_reset_mid_op();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
